m68k_bus_ctrl: RTL and testbench
================================

// Module: m68k_bus_ctrl
// PURPOSE
//  Parametrised 68000 bus-cycle controller replacing tied-off DTACKn/VPAn/BERRn/IPLn.
//  - Decodes each CPU cycle into one of N_REGIONS address regions.
//  - Per region: runtime wait states, external ready handshake, enable mask.
//  - Generates DTACKn, or BERRn on timeout or access to a disabled region.
//  - Handles interrupt-acknowledge cycles with autovector VPAn.
//  - Priority-encodes interrupt requests onto IPLn.
//  Sits between fx68k and the ROM/RAM/VRAM/peripheral decode in the top level.
// PARAMETERS
//  N_REGIONS    4   number of regions; must be a power of 2, >=2; RSEL=log2(N_REGIONS)
//  REGION_SHIFT 15  lowest cpu_a bit of the region field, cpu_a[REGION_SHIFT+RSEL-1:REGION_SHIFT]
//  WS_BITS      4   width of each per-region wait-state count
//  TIMEOUT      64  cycles from cycle start to BERR if no ack; must be > 2^WS_BITS+1
// PORTS
//  clk          in   1            CPU clock (clk_cpu domain)
//  reset_n      in   1            synchronous, active-low reset
//  as_n         in   1            CPU address strobe
//  rw           in   1            1=read, 0=write
//  uds_n,lds_n  in   1 each       byte strobes; passed to byte_en
//  fc           in   3            function code
//  cpu_a        in   23           address [23:1]
//  region_ws    in   N*WS_BITS    wait states; region r occupies [r*WS_BITS +: WS_BITS]
//  region_en    in   N_REGIONS    1=region populated
//  region_rdy   in   N_REGIONS    peripheral ready; tie high for fixed-latency memories
//  irq          in   7            irq[k] requests level k+1
//  dtack_n      out  1            data transfer acknowledge
//  berr_n       out  1            bus error
//  vpa_n        out  1            autovector request
//  ipl_n        out  3            encoded interrupt level, active low
//  sel          out  N_REGIONS    one-hot region select, held for the whole cycle
//  rd_stb       out  1            one-clk pulse at start of a read cycle
//  wr_stb       out  1            one-clk pulse at start of a write cycle
//  byte_en      out  2            {~uds_n,~lds_n}, latched at cycle start
//  iack_stb     out  1            one-clk pulse at start of an interrupt-ack cycle
//  iack_lvl     out  3            level being acknowledged (cpu_a[3:1]), latched
// BEHAVIOUR
//  Reset: dtack_n=1, berr_n=1, vpa_n=1, ipl_n=3'b111.
//   sel=0, strobes=0, byte_en=0, iack_lvl=0, state=IDLE, armed=0.
//  armed sets once as_n=1 is sampled. A reset mid-cycle never decodes the half-finished cycle.
//  Every transition is registered: outputs change on the clk edge after the condition is sampled.
//  IDLE, armed and as_n=0:
//   - fc=3'b111: go to IACK. Pulse iack_stb, latch iack_lvl.
//   - else if region_en[r]=0: go to BERR.
//   - else: go to WAIT. sel[r]=1, rd_stb or wr_stb pulses per rw, latch byte_en.
//     Load ws_cnt=region_ws[r]; clear tmo_cnt.
//  WAIT: ws_cnt decrements to 0; tmo_cnt increments every clk.
//   - ws_cnt==0 and region_rdy[r]=1: go to ACK, dtack_n=0. ws=0 with rdy high acks 2 clks after as_n falls.
//   - tmo_cnt==TIMEOUT-1 without ack: go to BERR. BERR wins if both hold on the same clk.
//  ACK: hold dtack_n=0 until as_n=1 is sampled. Then go to IDLE, dtack_n=1, sel=0.
//  BERR: berr_n=0 until as_n=1. Then go to IDLE, berr_n=1.
//  IACK: vpa_n=0 until as_n=1. Then go to IDLE, vpa_n=1. dtack_n stays 1 in IACK.
//  dtack_n, berr_n and vpa_n are mutually exclusive at all times.
//  as_n rising in WAIT (aborted cycle): return to IDLE next clk; no ack is issued.
//  IPL: registered every clk.
//   - ipl_n = ~(index of highest set irq bit + 1); ipl_n=3'b111 when irq=0.
//   - Independent of the bus state machine.
//  Counters: ws_cnt is WS_BITS wide and saturates at 0.
//   tmo_cnt is clog2(TIMEOUT) bits wide and never wraps; BERR is taken first.
// TESTING
//  1 Read, cpu_a=0x008000 (r=1), region_ws[1]=3, rdy=1 -> rd_stb 1 clk; sel=4'b0010.
//    dtack_n low 5 clks after as_n falls, high 1 clk after as_n rises.
//  2 Write, r=2, ws=0, uds_n=0, lds_n=1 -> wr_stb pulse, byte_en=2'b10, dtack_n low 2 clks after as_n falls.
//  3 Region 3 with region_en[3]=0 -> berr_n low 2 clks after as_n falls; no sel, no strobes.
//  4 rdy held 0, TIMEOUT=64 -> berr_n low exactly 65 clks after as_n falls; dtack_n never asserts.
//  5 irq=7'b0010100 -> ipl_n=3'b010 (level 5).
//    Then fc=7, cpu_a[3:1]=5 -> iack_stb pulse, iack_lvl=5, vpa_n low until as_n rises.
//  6 Assert reset_n=0 during WAIT with as_n held low, then release ->
//    all outputs at reset values; no decode until as_n goes high then low again.

Source files
------------

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus-cycle controller: region decode, wait states, ready handshake,
// DTACK/BERR/VPA generation and registered IPL priority encoding.
module m68k_bus_ctrl #(
  parameter int N_REGIONS    = 4,
  parameter int REGION_SHIFT = 15,
  parameter int WS_BITS      = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         as_n,
  input  logic                         rw,
  input  logic                         uds_n,
  input  logic                         lds_n,
  input  logic [2:0]                   fc,
  input  logic [23:1]                  cpu_a,
  input  logic [N_REGIONS*WS_BITS-1:0] region_ws,
  input  logic [N_REGIONS-1:0]         region_en,
  input  logic [N_REGIONS-1:0]         region_rdy,
  input  logic [6:0]                   irq,
  output logic                         dtack_n,
  output logic                         berr_n,
  output logic                         vpa_n,
  output logic [2:0]                   ipl_n,
  output logic [N_REGIONS-1:0]         sel,
  output logic                         rd_stb,
  output logic                         wr_stb,
  output logic [1:0]                   byte_en,
  output logic                         iack_stb,
  output logic [2:0]                   iack_lvl
);

  localparam int RSEL = $clog2(N_REGIONS);
  localparam int TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT, ACK, BERR, IACK} state_t;

  state_t                 state_q, state_d;
  logic                   armed_q;
  logic                   disabled_q;
  logic [RSEL-1:0]        region_q;
  logic [WS_BITS-1:0]     wsCnt_q;
  logic [TW-1:0]          tmoCnt_q;
  logic [N_REGIONS-1:0]   sel_q;
  logic                   rdStb_q, wrStb_q, iackStb_q;
  logic [1:0]             byteEn_q;
  logic [2:0]             iackLvl_q;
  logic [2:0]             ipl_q, ipl_d;
  logic [RSEL-1:0]        rsel;
  logic                   start;
  logic                   unusedAddr;

  assign rsel       = cpu_a[REGION_SHIFT +: RSEL];
  assign start      = (state_q == IDLE) && armed_q && !as_n;
  assign unusedAddr = ^cpu_a;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A disabled region passes through WAIT for one clock so its BERR lines up
  // with the earliest possible DTACK; timeout outranks a late ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (fc == 3'b111) ? IACK : WAIT;
      WAIT: begin
        if (as_n)                                          state_d = IDLE;
        else if (disabled_q || tmoCnt_q == TMO_LAST)       state_d = BERR;
        else if (wsCnt_q == '0 && region_rdy[region_q])    state_d = ACK;
      end
      default: if (as_n) state_d = IDLE;
    endcase
  end

  always_comb begin
    dtack_n  = (state_q != ACK);
    berr_n   = (state_q != BERR);
    vpa_n    = (state_q != IACK);
    ipl_n    = ipl_q;
    sel      = sel_q;
    rd_stb   = rdStb_q;
    wr_stb   = wrStb_q;
    byte_en  = byteEn_q;
    iack_stb = iackStb_q;
    iack_lvl = iackLvl_q;
  end

  always_comb begin
    ipl_d = 3'b111;
    for (int k = 0; k < 7; k++) begin
      if (irq[k]) ipl_d = ~3'(k + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      armed_q    <= 1'b0;
      disabled_q <= 1'b0;
      region_q   <= '0;
      wsCnt_q    <= '0;
      tmoCnt_q   <= '0;
      sel_q      <= '0;
      rdStb_q    <= 1'b0;
      wrStb_q    <= 1'b0;
      iackStb_q  <= 1'b0;
      byteEn_q   <= 2'b00;
      iackLvl_q  <= 3'b000;
      ipl_q      <= 3'b111;
    end else begin
      rdStb_q   <= 1'b0;
      wrStb_q   <= 1'b0;
      iackStb_q <= 1'b0;
      ipl_q     <= ipl_d;
      if (as_n) armed_q <= 1'b1;
      if (start) begin
        if (fc == 3'b111) begin
          iackStb_q <= 1'b1;
          iackLvl_q <= cpu_a[3:1];
        end else begin
          region_q   <= rsel;
          disabled_q <= !region_en[rsel];
          tmoCnt_q   <= '0;
          wsCnt_q    <= region_ws[int'(rsel)*WS_BITS +: WS_BITS];
          if (region_en[rsel]) begin
            sel_q    <= {{(N_REGIONS-1){1'b0}}, 1'b1} << rsel;
            rdStb_q  <= rw;
            wrStb_q  <= !rw;
            byteEn_q <= {~uds_n, ~lds_n};
          end
        end
      end else if (state_q == WAIT) begin
        if (wsCnt_q != '0)       wsCnt_q  <= wsCnt_q - 1'b1;
        if (tmoCnt_q != TMO_LAST) tmoCnt_q <= tmoCnt_q + 1'b1;
      end
      if (state_q != IDLE && state_d == IDLE) sel_q <= '0;
    end
  end

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench for m68k_bus_ctrl: expected bus-cycle outcomes are queued
// before each cycle and compared once the controller terminates it.
module tb_m68k_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        as_n = 1'b1;
  logic        rw = 1'b1;
  logic        uds_n = 1'b1;
  logic        lds_n = 1'b1;
  logic [2:0]  fc = 3'b101;
  logic [23:1] cpu_a = '0;
  logic [15:0] region_ws = {4'd5, 4'd0, 4'd3, 4'd2};
  logic [3:0]  region_en = 4'b0111;
  logic [3:0]  region_rdy = 4'b1111;
  logic [6:0]  irq = 7'b0;
  logic        dtack_n, berr_n, vpa_n;
  logic [2:0]  ipl_n;
  logic [3:0]  sel;
  logic        rd_stb, wr_stb, iack_stb;
  logic [1:0]  byte_en;
  logic [2:0]  iack_lvl;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    int         kind;
    int         lat;
    logic [3:0] sel;
    int         rd;
    int         wr;
    int         ia;
    logic       chkBe;
    logic [1:0] be;
    logic       chkLvl;
    logic [2:0] lvl;
  } expT;

  expT sb[$];

  m68k_bus_ctrl dut (
    .clk(clk), .reset_n(reset_n), .as_n(as_n), .rw(rw),
    .uds_n(uds_n), .lds_n(lds_n), .fc(fc), .cpu_a(cpu_a),
    .region_ws(region_ws), .region_en(region_en), .region_rdy(region_rdy),
    .irq(irq), .dtack_n(dtack_n), .berr_n(berr_n), .vpa_n(vpa_n),
    .ipl_n(ipl_n), .sel(sel), .rd_stb(rd_stb), .wr_stb(wr_stb),
    .byte_en(byte_en), .iack_stb(iack_stb), .iack_lvl(iack_lvl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushExp(input string tag, input int kind, input int lat, input logic [3:0] s,
                         input int rd, input int wr, input int ia,
                         input logic chkBe, input logic [1:0] be,
                         input logic chkLvl, input logic [2:0] lvl);
    expT e;
    e.tag = tag; e.kind = kind; e.lat = lat; e.sel = s;
    e.rd = rd; e.wr = wr; e.ia = ia;
    e.chkBe = chkBe; e.be = be; e.chkLvl = chkLvl; e.lvl = lvl;
    sb.push_back(e);
  endtask

  // kind: 0 = DTACK, 1 = BERR, 2 = VPA, 3 = no termination within the budget
  task automatic applyStimulus(input logic [23:0] addr, input logic rwv, input logic [2:0] fcv,
                               input logic udsv, input logic ldsv);
    expT e;
    int n = 0, kind = 3, rdC = 0, wrC = 0, iaC = 0, excl = 0, act;
    logic [3:0] selAt;
    logic [1:0] beAt;
    logic [2:0] lvlAt;
    cpu_a = addr[23:1]; rw = rwv; fc = fcv; uds_n = udsv; lds_n = ldsv; as_n = 1'b0;
    while (kind == 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      rdC += int'(rd_stb);
      wrC += int'(wr_stb);
      iaC += int'(iack_stb);
      act = int'(!dtack_n) + int'(!berr_n) + int'(!vpa_n);
      if (act > 1) excl++;
      if (!dtack_n)     kind = 0;
      else if (!berr_n) kind = 1;
      else if (!vpa_n)  kind = 2;
    end
    selAt = sel; beAt = byte_en; lvlAt = iack_lvl;
    e = sb.pop_front();
    checkOutput({e.tag, "_kind"}, kind, e.kind);
    checkOutput({e.tag, "_latency"}, n, e.lat);
    checkOutput({e.tag, "_sel"}, selAt, e.sel);
    checkOutput({e.tag, "_rdstb"}, rdC, e.rd);
    checkOutput({e.tag, "_wrstb"}, wrC, e.wr);
    checkOutput({e.tag, "_iackstb"}, iaC, e.ia);
    checkOutput({e.tag, "_exclusive"}, excl, 0);
    if (e.chkBe)  checkOutput({e.tag, "_byteen"}, beAt, e.be);
    if (e.chkLvl) checkOutput({e.tag, "_iacklvl"}, lvlAt, e.lvl);
    as_n = 1'b1;
    tick(1);
    checkOutput({e.tag, "_release"}, {dtack_n, berr_n, vpa_n, sel}, {3'b111, 4'b0000});
    tick(1);
  endtask

  initial begin
    int act;
    $display("[TB] start");
    tick(2);
    checkOutput("reset", {dtack_n, berr_n, vpa_n, ipl_n, sel, rd_stb, wr_stb, byte_en, iack_stb, iack_lvl},
                {3'b111, 3'b111, 4'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000});
    reset_n = 1'b1;
    tick(2);

    pushExp("rd_r1_ws3", 0, 5, 4'b0010, 1, 0, 0, 1'b1, 2'b11, 1'b0, 3'b0);
    applyStimulus(24'h008000, 1'b1, 3'b101, 1'b0, 1'b0);

    pushExp("wr_r2_ws0", 0, 2, 4'b0100, 0, 1, 0, 1'b1, 2'b10, 1'b0, 3'b0);
    applyStimulus(24'h010000, 1'b0, 3'b101, 1'b0, 1'b1);

    pushExp("disabled_r3", 1, 2, 4'b0000, 0, 0, 0, 1'b0, 2'b00, 1'b0, 3'b0);
    applyStimulus(24'h018000, 1'b1, 3'b101, 1'b0, 1'b0);

    region_rdy = 4'b1110;
    pushExp("timeout_r0", 1, 65, 4'b0001, 1, 0, 0, 1'b1, 2'b01, 1'b0, 3'b0);
    applyStimulus(24'h000100, 1'b1, 3'b101, 1'b1, 1'b0);
    region_rdy = 4'b1111;

    irq = 7'b0010100;
    tick(2);
    checkOutput("ipl_lvl5", ipl_n, 3'b010);
    irq = 7'b1000000;
    tick(2);
    checkOutput("ipl_lvl7", ipl_n, 3'b000);
    irq = 7'b0000001;
    tick(2);
    checkOutput("ipl_lvl1", ipl_n, 3'b110);
    irq = 7'b0010100;
    tick(2);

    pushExp("iack_lvl5", 2, 1, 4'b0000, 0, 0, 1, 1'b0, 2'b00, 1'b1, 3'd5);
    applyStimulus(24'h00000A, 1'b1, 3'b111, 1'b0, 1'b0);

    irq = 7'b0;
    region_rdy = 4'b1101;
    cpu_a = 23'h004000; rw = 1'b1; fc = 3'b101; as_n = 1'b0;
    tick(3);
    reset_n = 1'b0;
    tick(2);
    checkOutput("midreset", {dtack_n, berr_n, vpa_n, ipl_n, sel, rd_stb, wr_stb, byte_en, iack_stb, iack_lvl},
                {3'b111, 3'b111, 4'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000});
    reset_n = 1'b1;
    region_rdy = 4'b1111;
    act = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      act |= int'(!dtack_n) | int'(!berr_n) | int'(!vpa_n) | int'(|sel) | int'(rd_stb) | int'(wr_stb) | int'(iack_stb);
    end
    checkOutput("no_decode_after_reset", act, 0);
    as_n = 1'b1;
    tick(1);

    pushExp("rearmed_r1", 0, 5, 4'b0010, 1, 0, 0, 1'b1, 2'b11, 1'b0, 3'b0);
    applyStimulus(24'h008000, 1'b1, 3'b101, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
